// File: rtl/serial_pattern_generator_if.sv
// Handshake and data bundle for the serial pattern generator.
// master drives pattern/control and observes the stream; slave is the generator.
interface serial_pattern_generator_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] len;
  logic             start;
  logic             repeat_en;
  logic             stop;
  logic             x;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_left;

  modport master (
    output load, data_in, len, start, repeat_en, stop,
    input  x, busy, done, bits_left
  );

  modport slave (
    input  load, data_in, len, start, repeat_en, stop,
    output x, busy, done, bits_left
  );
endinterface

// File: rtl/serial_pattern_generator.sv
// Parallel-load, serial-out pattern source. Shifts a programmable-length
// pattern out MSB-first, one bit per clock, one-shot or gapless repeat.
module serial_pattern_generator #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  serial_pattern_generator_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow_pat;
  // Shadow length is kept as (length - 1): a full WIDTH-bit pattern with
  // WIDTH == 2**CNT_W would not fit in CNT_W bits otherwise.
  logic [CNT_W-1:0] shadow_last;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt;
  logic             done_q;

  // Clamp a requested length (0 or > WIDTH means WIDTH) and return length-1.
  function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] l);
    if (l == '0 || 32'(l) > WIDTH) return CNT_W'(WIDTH - 1);
    else                           return l - 1'b1;
  endfunction

  // Control FSM plus shadow/shift/count datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow_pat  <= '0;
      shadow_last <= CNT_W'(WIDTH - 1);
      shift_reg   <= '0;
      cnt         <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shadow_pat  <= bus.data_in;
            shadow_last <= last_idx(bus.len);
          end
          if (bus.start) begin
            // Same-cycle load bypasses the shadow so the new data goes out now.
            shift_reg <= bus.load ? bus.data_in : shadow_pat;
            cnt       <= bus.load ? last_idx(bus.len) : shadow_last;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.stop) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
          end else if (cnt != '0) begin
            shift_reg <= shift_reg << 1;
            cnt       <= cnt - 1'b1;
          end else if (bus.repeat_en) begin
            shift_reg <= shadow_pat;
            cnt       <= shadow_last;
          end else begin
            state     <= IDLE;
            shift_reg <= '0;
            done_q    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.x         = bus.busy & shift_reg[WIDTH-1];
  assign bus.done      = done_q;
  assign bus.bits_left = cnt;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Randomized and directed bench for serial_pattern_generator against a
// bit-queue reference model.
module tb_serial_pattern_generator;
  localparam int W = 24;
  localparam int C = 5;

  logic gclk = 1'b0;
  logic rst;
  always #5 gclk = ~gclk;

  serial_pattern_generator_if #(.WIDTH(W), .CNT_W(C)) bus ();
  serial_pattern_generator #(.WIDTH(W), .CNT_W(C)) dut (.clk(gclk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int fails  = 0;

  // Reference model: the rest of the current copy as a queue of bits.
  bit         mq[$];
  bit [W-1:0] m_pat;
  int         m_n;
  bit         m_busy;
  bit         m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int l);
    return (l == 0 || l > W) ? W : l;
  endfunction

  task automatic fill(input bit [W-1:0] p, input int n);
    mq.delete();
    for (int i = 0; i < n; i++) mq.push_back(p[W-1-i]);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pat  = '0;
    m_n    = W;
    m_busy = 0;
    m_done = 0;
  endtask

  task automatic model_edge();
    bit [W-1:0] p;
    int n;
    m_done = 0;
    if (!m_busy) begin
      p = m_pat;
      n = m_n;
      if (bus.load) begin
        m_pat = bus.data_in;
        m_n   = eff(int'(bus.len));
        p = m_pat;
        n = m_n;
      end
      if (bus.start) begin
        fill(p, n);
        m_busy = 1;
      end
    end else if (bus.stop) begin
      m_busy = 0;
      mq.delete();
    end else begin
      void'(mq.pop_front());
      if (mq.size() == 0) begin
        if (bus.repeat_en) fill(m_pat, m_n);
        else begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("x", 32'(bus.x), m_busy ? 32'(mq[0]) : 32'd0);
    chk("done", 32'(bus.done), 32'(m_done));
    chk("bits_left", 32'(bus.bits_left), m_busy ? 32'(mq.size() - 1) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge gclk);
    if (rst) model_edge();
    #1;
    check_outs();
  endtask

  task automatic ctl(input bit ld, input bit st, input bit sp);
    bus.load  = ld;
    bus.start = st;
    bus.stop  = sp;
  endtask

  int nb, nd, n1;
  bit [W-1:0] bits;

  initial begin
    model_reset();
    rst = 1'b0;
    bus.data_in = '0; bus.len = '0; bus.repeat_en = 1'b0;
    ctl(1, 1, 0);
    // Held in reset: start must not do anything.
    for (int i = 0; i < 3; i++) cycle();
    ctl(0, 0, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Full-width one-shot.
    bus.data_in = 24'h0C9094; bus.len = 0; ctl(1, 1, 0);
    nb = 0; bits = '0;
    for (int i = 0; i < W; i++) begin
      cycle();
      if (i == 0) ctl(0, 0, 0);
      bits = {bits[W-2:0], bus.x};
      if (bus.busy) nb++;
    end
    chk("oneshot_bits", 32'(bits), 32'h0C9094);
    chk("oneshot_busy", nb, W);
    cycle();
    chk("oneshot_done", 32'(bus.done), 1);
    cycle();

    // Repeat, then drop repeat_en during the third copy.
    bus.repeat_en = 1'b1; ctl(1, 1, 0);
    nb = 0; nd = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (i == 0) ctl(0, 0, 0);
      if (i == 59) bus.repeat_en = 1'b0;
      nb += int'(bus.busy);
      nd += int'(bus.done);
    end
    chk("repeat_busy", nb, 72);
    chk("repeat_done", nd, 1);

    // Short length and clamp.
    bus.data_in = 24'hA00000; bus.len = 3; ctl(1, 1, 0);
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      ctl(0, 0, 0);
      if (i < 3) bits = {bits[W-2:0], bus.x};
    end
    chk("short_bits", 32'(bits[2:0]), 32'h5);
    chk("short_done", 32'(bus.done), 1);
    bus.len = 31; ctl(1, 1, 0);
    nb = 0;
    for (int i = 0; i < 27; i++) begin
      cycle();
      ctl(0, 0, 0);
      nb += int'(bus.busy);
    end
    chk("clamp_busy", nb, W);

    // Abort after five bits.
    bus.data_in = 24'hFFFFFF; bus.len = 0; ctl(1, 1, 0);
    n1 = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      ctl(0, 0, i == 4);
      n1 += int'(bus.x);
      nd += int'(bus.done);
    end
    ctl(0, 0, 0);
    chk("abort_ones", n1, 5);
    chk("abort_done", nd, 0);

    // load/start while busy must not touch the stream or the shadow.
    bus.data_in = 24'h123456; bus.repeat_en = 1'b1; ctl(1, 1, 0);
    cycle();
    bus.data_in = 24'h000000; ctl(1, 1, 0);
    for (int i = 0; i < 30; i++) cycle();
    ctl(0, 0, 1);
    cycle();
    ctl(0, 0, 0); bus.repeat_en = 1'b0;
    cycle();

    // Asynchronous reset between edges.
    bus.data_in = 24'hFFFFFF; ctl(1, 1, 0);
    cycle();
    ctl(0, 0, 0);
    for (int i = 0; i < 9; i++) cycle();
    #2 rst = 1'b0;
    #1 model_reset();
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_x", 32'(bus.x), 0);
    check_outs();
    cycle();
    #2 rst = 1'b1;
    cycle();

    // Same-cycle load+start with one bit.
    bus.data_in = 24'h800000; bus.len = 1; ctl(1, 1, 0);
    cycle();
    ctl(0, 0, 0);
    chk("bypass_x", 32'(bus.x), 1);
    cycle();
    chk("bypass_done", 32'(bus.done), 1);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.load      = ($urandom_range(0, 3) == 0);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.stop      = ($urandom_range(0, 40) == 0);
      bus.data_in   = W'($urandom);
      bus.len       = C'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) bus.repeat_en = ~bus.repeat_en;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_outs();
        #1 rst = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
